multiply_16_unsigned: RTL and testbench

- Sequential 16x16 unsigned shift-and-add multiplier producing a full 32-bit product.
- Each step is one "multiply line": conditionally add the left-shifted multiplicand to the running partial product, then shift the multiplier right by one.
- Used as a shared arithmetic unit behind a valid/ready handshake.
- Operand buses are 32 bits wide for datapath compatibility; only the low 16 bits are multiplied.

---
 rtl/multiply_16_unsigned.sv | 148 ++++++++++++++
 tb/tb_multiply_16_unsigned.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multiply_16_unsigned.sv
// multiply_16_unsigned: sequential 16x16 unsigned shift-and-add multiplier.
// Each "multiply line" conditionally adds the shifted multiplicand to the
// partial product and then shifts the multiplier right by one.
// Operand buses are BUS_W bits wide; only the low WIDTH bits are multiplied.
// Optional feature macro: MULTIPLY_16_UNSIGNED_PIPELINE_EN
//   undefined (default): iterative unit, one multiply per WIDTH+1 cycles
//   defined            : fully unrolled WIDTH-stage pipeline, in_ready tied high
`timescale 1ns/1ps

module multiply_16_unsigned #(
    parameter int WIDTH = 16,
    parameter int BUS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] multiplicand,
    input  logic [BUS_W-1:0] multiplier,
    output logic             out_valid,
    output logic [BUS_W-1:0] product
);

    // One multiply line: add the shifted multiplicand when the current
    // multiplier bit is set. The sum never exceeds 2*WIDTH bits.
    function automatic logic [BUS_W-1:0] line_add(
        input logic [BUS_W-1:0] pp,
        input logic [BUS_W-1:0] mc,
        input logic             mp_bit
    );
        return mp_bit ? (pp + mc) : pp;
    endfunction

    logic [BUS_W-1:0] op_a;
    logic [BUS_W-1:0] op_b;
    logic             unused_upper;

    assign op_a = {{(BUS_W-WIDTH){1'b0}}, multiplicand[WIDTH-1:0]};
    assign op_b = {{(BUS_W-WIDTH){1'b0}}, multiplier[WIDTH-1:0]};

    // The upper operand bits are intentionally ignored.
    assign unused_upper = ^{multiplicand[BUS_W-1:WIDTH], multiplier[BUS_W-1:WIDTH]};

`ifdef MULTIPLY_16_UNSIGNED_PIPELINE_EN

    logic [BUS_W-1:0] st_pp [WIDTH];
    logic [BUS_W-1:0] st_mc [WIDTH];
    logic [BUS_W-1:0] st_mp [WIDTH];
    logic [WIDTH-1:0] st_valid;

    assign in_ready = 1'b1;

    // Stage 0 captures operands; stages 1..WIDTH-1 each perform one line.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                st_pp[i] <= '0;
                st_mc[i] <= '0;
                st_mp[i] <= '0;
            end
        end else begin
            st_valid[0] <= in_valid;
            st_pp[0]    <= '0;
            st_mc[0]    <= op_a;
            st_mp[0]    <= op_b;
            for (int i = 1; i < WIDTH; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_pp[i]    <= line_add(st_pp[i-1], st_mc[i-1], st_mp[i-1][0]);
                st_mc[i]    <= st_mc[i-1] << 1;
                st_mp[i]    <= st_mp[i-1] >> 1;
            end
        end
    end

    // Final line feeds the product register, which holds until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= st_valid[WIDTH-1];
            if (st_valid[WIDTH-1]) begin
                product <= line_add(st_pp[WIDTH-1], st_mc[WIDTH-1], st_mp[WIDTH-1][0]);
            end
        end
    end

`else

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state;
    logic [BUS_W-1:0] pp;
    logic [BUS_W-1:0] mc;
    logic [BUS_W-1:0] mp;
    logic [CNT_W-1:0] count;
    logic [BUS_W-1:0] pp_next;

    assign in_ready = (state == ST_IDLE);
    assign pp_next  = line_add(pp, mc, mp[0]);

    // Accept operands when idle, then run exactly WIDTH lines regardless of
    // operand values; the last line writes the product and pulses out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pp        <= '0;
            mc        <= '0;
            mp        <= '0;
            count     <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        pp    <= '0;
                        mc    <= op_a;
                        mp    <= op_b;
                        count <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    pp    <= pp_next;
                    mc    <= mc << 1;
                    mp    <= mp >> 1;
                    count <= count + 1'b1;
                    if (count == LAST_LINE) begin
                        product   <= pp_next;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_multiply_16_unsigned.sv
// tb_multiply_16_unsigned: scoreboard bench for multiply_16_unsigned.
// The driver pushes the hand-computed product and accept edge on every
// accepted operation; an independent monitor pops and compares on out_valid.
`timescale 1ns/1ps

module tb_multiply_16_unsigned;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        out_valid;
    logic [31:0] product;

    logic [31:0] exp_q [$];
    int          edge_q [$];
    int          edge_cnt = 0;
    int          checks = 0;
    int          passes = 0;
    int          last_accept = 0;
    logic        accepted;

`ifdef MULTIPLY_16_UNSIGNED_PIPELINE_EN
    localparam int ACCEPT_GAP = 1;
`else
    localparam int ACCEPT_GAP = 17;
`endif

    multiply_16_unsigned dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .product      (product)
    );

    always #5 clk = ~clk;

    // Count rising edges so latency can be measured in edges.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual === required) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
    endtask

    // Present operands at a falling edge and hold them until accepted.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp);
        int waited = 0;
        accepted     = 1'b0;
        in_valid     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        while (in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            $display("[TB] FAIL accept_timeout: in_ready never rose for a=0x%08h b=0x%08h", a, b);
        end else begin
            @(posedge clk);
            #1;
            exp_q.push_back(exp);
            edge_q.push_back(edge_cnt);
            last_accept = edge_cnt;
            accepted    = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been seen.
    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
            edge_q.delete();
        end
    endtask

    // Monitor: compare each out_valid pulse against the scoreboard head.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_out_valid: got product 0x%08h, required no output", product);
            end else begin
                logic [31:0] e;
                int          ae;
                e  = exp_q.pop_front();
                ae = edge_q.pop_front();
                checkOutput("product", product, e);
                checkOutput("latency_edge", 32'(edge_cnt), 32'(ae + 16));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] dir_b   [4] = '{32'h0000_0001, 32'h0000_0011, 32'h0000_0111, 32'h0000_1111};
        logic [31:0] dir_exp [4] = '{32'h0000_1111, 32'h0001_2221, 32'h0012_3321, 32'h0123_4321};
        int          prev;

        rst          = 1'b1;
        in_valid     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_product", product, 32'h0);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'h1);
        repeat (2) @(negedge clk);

        // Directed sequence, issued back to back.
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h0000_1111, dir_b[i], dir_exp[i]);
            if (i > 0 && accepted)
                checkOutput("accept_gap", 32'(last_accept - prev), 32'(ACCEPT_GAP));
            prev = last_accept;
        end
        drain();

        // Corner operands.
        applyStimulus(32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001);
        applyStimulus(32'h0000_0000, 32'h0000_1234, 32'h0000_0000);
        applyStimulus(32'hABCD_0003, 32'h9876_0005, 32'h0000_000F);
        drain();

`ifndef MULTIPLY_16_UNSIGNED_PIPELINE_EN
        // Busy: in_valid stays high with new operands; none may be accepted.
        applyStimulus(32'h0000_0007, 32'h0000_0009, 32'h0000_003F);
        for (int i = 0; i < 10; i++) begin
            in_valid     = 1'b1;
            multiplicand = 32'h0000_0100 + 32'(i);
            multiplier   = 32'h0000_0200 + 32'(i);
            checkOutput("busy_in_ready", {31'b0, in_ready}, 32'h0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();
        repeat (20) @(negedge clk);
`endif

        // Reset in the middle of an operation aborts it.
        applyStimulus(32'h0000_1234, 32'h0000_5678, 32'h0626_0060);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        edge_q.delete();
        checkOutput("midreset_product", product, 32'h0);
        checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("midreset_in_ready", {31'b0, in_ready}, 32'h1);
        repeat (20) @(negedge clk);
        applyStimulus(32'h0000_0010, 32'h0000_0010, 32'h0000_0100);
        drain();

`ifdef MULTIPLY_16_UNSIGNED_PIPELINE_EN
        // Pipeline: 20 operand pairs on consecutive cycles.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom();
            b = $urandom();
            applyStimulus(a, b, {16'b0, a[15:0]} * {16'b0, b[15:0]});
        end
        drain();
`endif

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
